bus_xfer_engine: RTL and testbench

- Parametrised, registered successor to the combinational micro-bus source mux.
- Accepts queued transfer requests (source index, destination index, mode) from the micro-sequencer and captures the selected source onto a registered shared bus.
- Asserts a one-hot destination write strobe until the destination accepts it; resolves conditional (cc_greater / cc_equal) branch-target selection in hardware.
- Sits between micro-decode/datapath producers and all bus consumers (ALU operand regs, reg file, m_pc).

---
 rtl/bus_xfer_pkg.sv | 27 ++
 rtl/bus_xfer_fifo.sv | 49 ++++
 rtl/bus_xfer_engine.sv | 120 ++++++++++++
 tb/tb_bus_xfer_engine.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_xfer_pkg.sv
// Shared types for the bus transfer engine:
// mode encodings, FSM states and the queued request record.
package bus_xfer_pkg;

    localparam int SRC_IDX_W = 3;
    localparam int DST_IDX_W = 4;

    typedef enum logic [1:0] {
        MODE_PLAIN = 2'b00,
        MODE_CC_GT = 2'b01,
        MODE_CC_EQ = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    typedef struct packed {
        logic [SRC_IDX_W-1:0] src;
        logic [SRC_IDX_W-1:0] alt_src;
        logic [DST_IDX_W-1:0] dst;
        mode_e                mode;
    } xfer_req_t;

endpackage

// File: rtl/bus_xfer_fifo.sv
// Circular request queue; pointers carry an extra wrap bit
// so full and empty are told apart without a counter.
module bus_xfer_fifo
    import bus_xfer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  xfer_req_t wdata,
    input  logic      pop,
    output xfer_req_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    xfer_req_t     mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; a full queue refuses pushes even when popping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bus_xfer_engine.sv
// Registered shared-bus transfer engine: queues requests, resolves
// conditional source selection and strobes the target until accepted.
module bus_xfer_engine
    import bus_xfer_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SRC     = 8,
    parameter int NUM_DST     = 16,
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [$clog2(NUM_SRC)-1:0]    req_src,
    input  logic [$clog2(NUM_SRC)-1:0]    req_alt_src,
    input  logic [$clog2(NUM_DST)-1:0]    req_dst,
    input  logic [1:0]                    req_mode,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic                          cc_greater,
    input  logic                          cc_equal,
    input  logic [NUM_DST-1:0]            dst_ready,
    output logic [DATA_WIDTH-1:0]         bus_data,
    output logic [NUM_DST-1:0]            dst_we,
    output logic                          busy,
    output logic                          err_invalid,
    input  logic                          err_clr,
    output logic [CNT_WIDTH-1:0]          xfer_count
);

    state_e                 state_q;
    state_e                 state_d;
    xfer_req_t              push_req;
    xfer_req_t              head;
    logic                   full;
    logic                   empty;
    logic                   issue;
    logic                   complete;
    logic                   src_bad;
    logic                   dst_bad;
    logic [SRC_IDX_W-1:0]   sel;
    logic [DATA_WIDTH-1:0]  src_val;
    logic [DST_IDX_W-1:0]   dst_q;

    assign req_ready        = !full && !sys_rst;
    assign push_req.src     = SRC_IDX_W'(req_src);
    assign push_req.alt_src = SRC_IDX_W'(req_alt_src);
    assign push_req.dst     = DST_IDX_W'(req_dst);
    assign push_req.mode    = mode_e'(req_mode);
    assign busy             = !empty || (state_q == DRIVE);
    assign complete         = |(dst_we & dst_ready);

    bus_xfer_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (req_valid && req_ready),
        .wdata (push_req),
        .pop   (issue),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // One-hot strobe toward the registered destination while driving.
    always_comb begin
        dst_we = '0;
        for (int i = 0; i < NUM_DST; i++) begin
            dst_we[i] = (state_q == DRIVE) && (int'(dst_q) == i);
        end
    end

    // Source mux; an out-of-range index yields zero.
    always_comb begin
        src_val = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(sel) == i) src_val = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Issue decision, conditional source pick and next state.
    always_comb begin
        state_d = state_q;
        issue   = !empty && ((state_q == IDLE) || complete);
        sel     = head.src;
        unique case (head.mode)
            MODE_CC_GT: sel = cc_greater ? head.src : head.alt_src;
            MODE_CC_EQ: sel = cc_equal   ? head.src : head.alt_src;
            default:    sel = head.src;
        endcase
        src_bad = int'(sel) >= NUM_SRC;
        dst_bad = int'(head.dst) >= NUM_DST;
        if (complete) state_d = IDLE;
        if (issue)    state_d = dst_bad ? IDLE : DRIVE;
    end

    // State, bus register, error flag and completion counter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            bus_data    <= '0;
            dst_q       <= '0;
            err_invalid <= 1'b0;
            xfer_count  <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                bus_data <= src_val;
                dst_q    <= head.dst;
            end
            if (issue && (src_bad || dst_bad)) err_invalid <= 1'b1;
            else if (err_clr)                  err_invalid <= 1'b0;
            xfer_count <= xfer_count + CNT_WIDTH'(complete)
                                     + CNT_WIDTH'(issue && dst_bad);
        end
    end

endmodule

// File: tb/tb_bus_xfer_engine.sv
// Directed bench for bus_xfer_engine, built with 6 sources and
// 12 destinations so out-of-range indices are reachable.
module tb_bus_xfer_engine;

    localparam int DW = 8;
    localparam int NS = 6;
    localparam int ND = 12;
    localparam int CW = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_src;
    logic [2:0]    req_alt_src;
    logic [3:0]    req_dst;
    logic [1:0]    req_mode;
    logic [NS*DW-1:0] src_data;
    logic          cc_greater;
    logic          cc_equal;
    logic [ND-1:0] dst_ready;
    logic [DW-1:0] bus_data;
    logic [ND-1:0] dst_we;
    logic          busy;
    logic          err_invalid;
    logic          err_clr;
    logic [CW-1:0] xfer_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    logic [7:0] drain_bus [5];

    bus_xfer_engine #(
        .DATA_WIDTH  (DW),
        .NUM_SRC     (NS),
        .NUM_DST     (ND),
        .QUEUE_DEPTH (4),
        .CNT_WIDTH   (CW)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_src     (req_src),
        .req_alt_src (req_alt_src),
        .req_dst     (req_dst),
        .req_mode    (req_mode),
        .src_data    (src_data),
        .cc_greater  (cc_greater),
        .cc_equal    (cc_equal),
        .dst_ready   (dst_ready),
        .bus_data    (bus_data),
        .dst_we      (dst_we),
        .busy        (busy),
        .err_invalid (err_invalid),
        .err_clr     (err_clr),
        .xfer_count  (xfer_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] s, input logic [2:0] a,
                        input logic [3:0] d, input logic [1:0] m);
        req_src     = s;
        req_alt_src = a;
        req_dst     = d;
        req_mode    = m;
        req_valid   = 1'b1;
        tick();
        req_valid   = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [2:0] s,
                        input logic [2:0] a, input logic [3:0] d,
                        input logic [1:0] m, input logic [7:0] ebus,
                        input logic [11:0] ewe);
        push(s, a, d, m);
        tick();
        chk({tag, "_bus"}, 32'(bus_data), 32'(ebus));
        chk({tag, "_we"}, 32'(dst_we), 32'(ewe));
        tick();
        exp_cnt++;
        chk({tag, "_we_off"}, 32'(dst_we), 32'h0);
        chk({tag, "_cnt"}, 32'(xfer_count), exp_cnt);
    endtask

    initial begin
        sys_rst     = 1'b1;
        req_valid   = 1'b0;
        req_src     = '0;
        req_alt_src = '0;
        req_dst     = '0;
        req_mode    = 2'b00;
        src_data    = {8'h12, 8'h40, 8'h33, 8'h5A, 8'h22, 8'h11};
        cc_greater  = 1'b0;
        cc_equal    = 1'b0;
        dst_ready   = '1;
        err_clr     = 1'b0;
        drain_bus   = '{8'h11, 8'h22, 8'h5A, 8'h33, 8'h40};

        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_we", 32'(dst_we), 32'h0);
        chk("rst_bus", 32'(bus_data), 32'h0);
        chk("rst_cnt", 32'(xfer_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err_invalid), 32'h0);
        sys_rst = 1'b0;
        #1;
        chk("ready_up", 32'(req_ready), 32'h1);

        // Single plain transfer with latency check.
        push(3'd2, 3'd0, 4'd3, 2'b00);
        chk("p1_busy_q", 32'(busy), 32'h1);
        chk("p1_we_wait", 32'(dst_we), 32'h0);
        tick();
        chk("p1_we", 32'(dst_we), 32'h008);
        chk("p1_bus", 32'(bus_data), 32'h5A);
        tick();
        exp_cnt++;
        chk("p1_we_off", 32'(dst_we), 32'h0);
        chk("p1_cnt", 32'(xfer_count), exp_cnt);
        chk("p1_idle", 32'(busy), 32'h0);

        // Conditional modes and reserved encoding.
        cc_greater = 1'b1;
        xfer("gt1", 3'd4, 3'd5, 4'd1, 2'b01, 8'h40, 12'h002);
        cc_greater = 1'b0;
        xfer("gt0", 3'd4, 3'd5, 4'd1, 2'b01, 8'h12, 12'h002);
        cc_equal = 1'b1;
        xfer("eq1", 3'd4, 3'd5, 4'd1, 2'b10, 8'h40, 12'h002);
        cc_equal = 1'b0;
        xfer("eq0", 3'd4, 3'd5, 4'd1, 2'b10, 8'h12, 12'h002);
        cc_greater = 1'b1;
        xfer("rsvd", 3'd2, 3'd4, 4'd1, 2'b11, 8'h5A, 12'h002);
        cc_greater = 1'b0;

        // Fill queue with consumers stalled, then drain.
        dst_ready = '0;
        for (int i = 0; i < 5; i++) begin
            req_src   = 3'(i);
            req_dst   = 4'(i);
            req_mode  = 2'b00;
            req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        chk("fill_ready", 32'(req_ready), 32'h0);
        chk("fill_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain%0d_we", i), 32'(dst_we), 32'(1 << i));
            chk($sformatf("drain%0d_bus", i), 32'(bus_data), 32'(drain_bus[i]));
            if (i == 0) dst_ready = '1;
            tick();
        end
        exp_cnt += 5;
        chk("drain_we_off", 32'(dst_we), 32'h0);
        chk("drain_cnt", 32'(xfer_count), exp_cnt);
        chk("drain_ready", 32'(req_ready), 32'h1);

        // Stalled target; other ready bits high.
        dst_ready = 12'hF7F;
        push(3'd3, 3'd0, 4'd7, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_we", i), 32'(dst_we), 32'h080);
            chk($sformatf("stall%0d_bus", i), 32'(bus_data), 32'h33);
            chk($sformatf("stall%0d_cnt", i), 32'(xfer_count), exp_cnt);
        end
        dst_ready = '1;
        tick();
        exp_cnt++;
        chk("stall_we_off", 32'(dst_we), 32'h0);
        chk("stall_cnt", 32'(xfer_count), exp_cnt);

        // Bad source index on a plain transfer.
        push(3'd7, 3'd0, 4'd5, 2'b00);
        tick();
        chk("bsrc_bus", 32'(bus_data), 32'h0);
        chk("bsrc_we", 32'(dst_we), 32'h020);
        chk("bsrc_err", 32'(err_invalid), 32'h1);
        tick();
        exp_cnt++;
        chk("bsrc_cnt", 32'(xfer_count), exp_cnt);
        err_clr = 1'b1;
        tick();
        chk("clr_err", 32'(err_invalid), 32'h0);

        // Bad alternate (index == NUM_SRC); set beats clear.
        push(3'd2, 3'd6, 4'd2, 2'b01);
        tick();
        chk("balt_bus", 32'(bus_data), 32'h0);
        chk("balt_we", 32'(dst_we), 32'h004);
        chk("balt_err", 32'(err_invalid), 32'h1);
        tick();
        exp_cnt++;
        chk("balt_clr", 32'(err_invalid), 32'h0);
        chk("balt_cnt", 32'(xfer_count), exp_cnt);
        err_clr = 1'b0;

        // Bad destinations: no strobe, count at issue.
        push(3'd2, 3'd0, 4'd14, 2'b00);
        tick();
        exp_cnt++;
        chk("bdst14_we", 32'(dst_we), 32'h0);
        chk("bdst14_cnt", 32'(xfer_count), exp_cnt);
        chk("bdst14_err", 32'(err_invalid), 32'h1);
        chk("bdst14_busy", 32'(busy), 32'h0);
        push(3'd1, 3'd0, 4'd12, 2'b00);
        tick();
        exp_cnt++;
        chk("bdst12_we", 32'(dst_we), 32'h0);
        chk("bdst12_cnt", 32'(xfer_count), exp_cnt);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("bdst_clr", 32'(err_invalid), 32'h0);

        // Reset while driving with two queued.
        dst_ready = '0;
        for (int i = 0; i < 3; i++) begin
            req_src   = 3'(i);
            req_dst   = 4'(i);
            req_mode  = 2'b00;
            req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        chk("mr_we_pre", 32'(dst_we), 32'h001);
        sys_rst = 1'b1;
        #1;
        chk("mr_ready", 32'(req_ready), 32'h0);
        tick();
        chk("mr_we", 32'(dst_we), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_cnt", 32'(xfer_count), 32'h0);
        chk("mr_bus", 32'(bus_data), 32'h0);
        sys_rst = 1'b0;
        dst_ready = '1;
        tick();
        tick();
        chk("mr_after_busy", 32'(busy), 32'h0);
        chk("mr_after_we", 32'(dst_we), 32'h0);
        chk("mr_after_cnt", 32'(xfer_count), 32'h0);
        chk("mr_after_ready", 32'(req_ready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
